// File: rtl/gpr_pkg.sv
// Shared GPR geometry constants, used by the register file, decode and the writeback arbiter.
package gpr_pkg;
  localparam int unsigned GPR_ADDR_W = 5;
  localparam int unsigned GPR_DATA_W = 32;
  localparam logic [GPR_ADDR_W-1:0] GPR_ZERO_ADDR = 5'd0;
endpackage

// File: rtl/gpr_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after i_ptr, wrapping.
module gpr_rr_pick #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [PTR_W-1:0]   o_idx,
  output logic               o_any
);

  int unsigned w_k;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_k     = 0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      w_k = (int'(i_ptr) + off) % NUM_REQ;
      if (!o_any && i_valid[w_k]) begin
        o_any        = 1'b1;
        o_grant[w_k] = 1'b1;
        o_idx        = PTR_W'(w_k);
      end
    end
  end

endmodule

// File: rtl/gpr_wb_arbiter.sv
// Round-robin arbiter sharing the single GPR write port among NUM_REQ writeback sources.
module gpr_wb_arbiter
  import gpr_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned ADDR_W  = GPR_ADDR_W,
  parameter int unsigned DATA_W  = GPR_DATA_W,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wb_stall,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]    req_data,
  output logic                         gpr_we,
  output logic [ADDR_W-1:0]            gpr_addr,
  output logic [DATA_W-1:0]            gpr_wdata,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic [CNT_W-1:0]             wr_count
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0]   r_ptr;
  logic               r_we;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_data;
  logic [PTR_W-1:0]   r_id;
  logic [CNT_W-1:0]   r_cnt;

  logic [NUM_REQ-1:0] w_grant;
  logic [PTR_W-1:0]   w_idx;
  logic               w_any;
  logic               w_xfer;
  logic               w_commit;
  logic [ADDR_W-1:0]  w_addr [NUM_REQ];
  logic [DATA_W-1:0]  w_data [NUM_REQ];
  logic [ADDR_W-1:0]  w_sel_addr;
  logic [DATA_W-1:0]  w_sel_data;
  logic [PTR_W-1:0]   w_ptr_next;

  gpr_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .i_valid (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_addr[i] = req_addr[i*ADDR_W +: ADDR_W];
      w_data[i] = req_data[i*DATA_W +: DATA_W];
    end
  end

  // Grant is suppressed combinationally while in reset or stalled.
  assign req_ready  = (rst_n && !wb_stall) ? w_grant : '0;
  assign w_xfer     = w_any && rst_n && !wb_stall;
  assign w_sel_addr = w_addr[w_idx];
  assign w_sel_data = w_data[w_idx];
  assign w_commit   = w_xfer && (w_sel_addr != ADDR_W'(GPR_ZERO_ADDR));
  assign w_ptr_next = (w_idx == PTR_W'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr  <= '0;
      r_we   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
      r_id   <= '0;
      r_cnt  <= '0;
    end else begin
      r_we <= w_commit;
      if (w_xfer) begin
        r_addr <= w_sel_addr;
        r_data <= w_sel_data;
        r_id   <= w_idx;
        r_ptr  <= w_ptr_next;
      end
      // Counter advances with the write it accounts for, so it tracks gpr_we cycle-for-cycle.
      if (w_commit && (r_cnt != '1)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign gpr_we    = r_we;
  assign gpr_addr  = r_addr;
  assign gpr_wdata = r_data;
  assign grant_id  = r_id;
  assign wr_count  = r_cnt;

endmodule
